// File: rtl/cpu_hs_if.sv
// rtl/cpu_hs_if.sv - instruction and data memory handshake bundle for cpu_hs
interface cpu_hs_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ready;
  logic [15:0]   imem_rdata;
  logic          dmem_req;
  logic          dmem_we;
  logic [AW-1:0] dmem_addr;
  logic [DW-1:0] dmem_wdata;
  logic          dmem_ready;
  logic [DW-1:0] dmem_rdata;

  modport master (
    output imem_req, imem_addr,
    input  imem_ready, imem_rdata,
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_ready, dmem_rdata
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ready, imem_rdata,
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_ready, dmem_rdata
  );
endinterface

// File: rtl/cpu_hs.sv
// rtl/cpu_hs.sv - multi-cycle 16-bit-instruction core with handshaked imem/dmem
module cpu_hs #(
  parameter int DW = 16,
  parameter int AW = 16,
  parameter int CW = 32
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            start,
  input  logic            stop,
  cpu_hs_if.master        bus,
  output logic            running,
  output logic            halted,
  output logic [2:0]      state,
  output logic [AW-1:0]   dbg_pc,
  output logic [15:0]     dbg_ir,
  output logic [8*DW-1:0] dbg_regs,
  output logic [CW-1:0]   cyc_cnt,
  output logic [CW-1:0]   ret_cnt
);
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_F = 3'd1, S_D = 3'd2, S_X = 3'd3, S_M = 3'd4, S_W = 3'd5
  } state_t;

  localparam logic [3:0] OP_ADD = 4'h1, OP_SUB = 4'h2, OP_MLT = 4'h3, OP_SGT = 4'h4,
                         OP_AND = 4'h5, OP_OR = 4'h6, OP_LI = 4'h7, OP_LD = 4'h8,
                         OP_ST = 4'h9, OP_B = 4'hA, OP_BZ = 4'hB, OP_BNZ = 4'hC,
                         OP_HALT = 4'hF;

  state_t        st, st_nxt;
  logic [AW-1:0] pc, br_target;
  logic [15:0]   ir;
  logic [DW-1:0] regs [8];
  logic [DW-1:0] sr1, sr2, t, dr, alu_q;
  logic          br_taken, stop_flag;

  logic [3:0]    op;
  logic [2:0]    rd, rs1, rs2;
  logic [DW-1:0] imm9, off12, alu;
  logic          taken, wr_en;
  logic [AW-1:0] target;

  assign op    = ir[15:12];
  assign rd    = ir[11:9];
  assign rs1   = ir[8:6];
  assign rs2   = ir[5:3];
  assign imm9  = {{(DW-9){ir[8]}}, ir[8:0]};
  assign off12 = {{(DW-12){ir[11]}}, ir[11:0]};
  assign wr_en = (op >= OP_ADD) && (op <= OP_LD);

  always_comb begin
    st_nxt = st;
    case (st)
      S_IDLE: if (start && !stop) st_nxt = S_F;
      S_F:    if (bus.imem_ready) st_nxt = S_D;
      S_D:    st_nxt = (op == OP_LD || op == OP_ST) ? S_M : S_X;
      S_X:    st_nxt = S_W;
      S_M:    if (bus.dmem_ready) st_nxt = S_W;
      S_W:    st_nxt = (op == OP_HALT || stop_flag || stop) ? S_IDLE : S_F;
      default: st_nxt = S_IDLE;
    endcase
  end

  // pc already points past the branch when X runs
  always_comb begin
    alu    = '0;
    taken  = 1'b0;
    target = pc + off12[AW-1:0];
    case (op)
      OP_ADD: alu = sr1 + sr2;
      OP_SUB: alu = sr1 - sr2;
      OP_MLT: alu = sr1 * sr2;
      OP_SGT: alu = DW'($signed(sr1) > $signed(sr2));
      OP_AND: alu = sr1 & sr2;
      OP_OR:  alu = sr1 | sr2;
      OP_LI:  alu = imm9;
      OP_B:   taken = 1'b1;
      OP_BZ:  begin taken = (t == '0); target = pc + imm9[AW-1:0]; end
      OP_BNZ: begin taken = (t != '0); target = pc + imm9[AW-1:0]; end
      default: alu = '0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      st        <= S_IDLE;
      pc        <= '0;
      ir        <= '0;
      sr1       <= '0;
      sr2       <= '0;
      t         <= '0;
      dr        <= '0;
      alu_q     <= '0;
      br_taken  <= 1'b0;
      br_target <= '0;
      halted    <= 1'b0;
      stop_flag <= 1'b0;
      cyc_cnt   <= '0;
      ret_cnt   <= '0;
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else begin
      st <= st_nxt;
      if (st != S_IDLE) cyc_cnt <= cyc_cnt + CW'(1);
      if (st_nxt == S_IDLE) stop_flag <= 1'b0;
      else if (stop)        stop_flag <= 1'b1;
      case (st)
        S_IDLE: if (st_nxt == S_F) halted <= 1'b0;
        S_F: if (bus.imem_ready) begin
          ir <= bus.imem_rdata;
          pc <= pc + AW'(1);
        end
        S_D: begin
          sr1      <= regs[rs1];
          sr2      <= regs[rs2];
          t        <= regs[rd];
          br_taken <= 1'b0;
        end
        S_X: begin
          alu_q     <= alu;
          br_taken  <= taken;
          br_target <= target;
        end
        S_M: if (bus.dmem_ready && op == OP_LD) dr <= bus.dmem_rdata;
        S_W: begin
          if (wr_en) regs[rd] <= (op == OP_LD) ? dr : alu_q;
          if (br_taken) pc <= br_target;
          ret_cnt <= ret_cnt + CW'(1);
          if (op == OP_HALT) halted <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.imem_req   = (st == S_F);
  assign bus.imem_addr  = pc;
  assign bus.dmem_req   = (st == S_M);
  assign bus.dmem_we    = (st == S_M) && (op == OP_ST);
  assign bus.dmem_addr  = sr1[AW-1:0];
  assign bus.dmem_wdata = sr2;

  assign running = (st != S_IDLE);
  assign state   = st;
  assign dbg_pc  = pc;
  assign dbg_ir  = ir;

  always_comb begin
    dbg_regs = '0;
    for (int i = 0; i < 8; i++) dbg_regs[i*DW +: DW] = regs[i];
  end
endmodule

// File: tb/tb_cpu_hs.sv
// tb/tb_cpu_hs.sv - directed self-checking bench for cpu_hs
module tb_cpu_hs;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, stop, start32, stop32;
  int   n_checks, n_errors;

  cpu_hs_if #(.AW(16), .DW(16)) bus0();
  cpu_hs_if #(.AW(16), .DW(32)) bus1();

  logic         running0, halted0, running1, halted1;
  logic [2:0]   state0, state1;
  logic [15:0]  pc0, ir0, pc1, ir1;
  logic [127:0] regs0;
  logic [255:0] regs1;
  logic [31:0]  cyc0, ret0, cyc1, ret1;

  cpu_hs #(.DW(16), .AW(16), .CW(32)) u0 (
    .CLK(clk), .RST(rst), .start(start), .stop(stop), .bus(bus0),
    .running(running0), .halted(halted0), .state(state0), .dbg_pc(pc0),
    .dbg_ir(ir0), .dbg_regs(regs0), .cyc_cnt(cyc0), .ret_cnt(ret0)
  );

  cpu_hs #(.DW(32), .AW(16), .CW(32)) u1 (
    .CLK(clk), .RST(rst), .start(start32), .stop(stop32), .bus(bus1),
    .running(running1), .halted(halted1), .state(state1), .dbg_pc(pc1),
    .dbg_ir(ir1), .dbg_regs(regs1), .cyc_cnt(cyc1), .ret_cnt(ret1)
  );

  logic [15:0] imem [256];
  logic [15:0] dmem [256];
  int          iwait, dwait, i_cnt, d_cnt, unstable;
  logic        i_rdy, d_rdy, d_we_q;
  logic [15:0] i_addr_q, d_addr_q, d_wdata_q;

  assign bus0.imem_ready = i_rdy;
  assign bus0.imem_rdata = imem[bus0.imem_addr[7:0]];
  assign bus0.dmem_ready = d_rdy;
  assign bus0.dmem_rdata = dmem[bus0.dmem_addr[7:0]];
  assign bus1.imem_ready = 1'b1;
  assign bus1.imem_rdata = imem[bus1.imem_addr[7:0]];
  assign bus1.dmem_ready = 1'b1;
  assign bus1.dmem_rdata = '0;

  // Wait-state responder; also counts request fields that move while waiting
  initial unstable = 0;
  always @(negedge clk) begin
    if (bus0.imem_req === 1'b1) begin
      if (i_cnt > 0 && bus0.imem_addr !== i_addr_q) unstable++;
      i_addr_q = bus0.imem_addr;
      i_rdy    = (i_cnt >= iwait);
      i_cnt++;
    end else begin
      i_cnt = 0;
      i_rdy = 1'b0;
    end
    if (bus0.dmem_req === 1'b1) begin
      if (d_cnt > 0 && (bus0.dmem_addr !== d_addr_q || bus0.dmem_wdata !== d_wdata_q ||
                        bus0.dmem_we !== d_we_q)) unstable++;
      d_addr_q  = bus0.dmem_addr;
      d_wdata_q = bus0.dmem_wdata;
      d_we_q    = bus0.dmem_we;
      d_rdy     = (d_cnt >= dwait);
      d_cnt++;
    end else begin
      d_cnt = 0;
      d_rdy = 1'b0;
    end
  end

  always @(posedge clk)
    if (bus0.dmem_req && bus0.dmem_ready && bus0.dmem_we)
      dmem[bus0.dmem_addr[7:0]] <= bus0.dmem_wdata;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) imem[i] = 16'hF000;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_idle0(input int budget, input string tag);
    int n = 0;
    while (running0 === 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, running0, 1'b0);
  endtask

  initial begin
    int n;
    int u_before;
    n_checks = 0; n_errors = 0;
    rst = 1'b1; start = 1'b0; stop = 1'b0; start32 = 1'b0; stop32 = 1'b0;
    iwait = 0; dwait = 0;
    clear_imem();

    // Reset state
    do_reset();
    check("rst_state", state0, 3'd0);
    check("rst_running", running0, 1'b0);
    check("rst_imem_req", bus0.imem_req, 1'b0);
    check("rst_dmem_req", bus0.dmem_req, 1'b0);
    check("rst_pc", pc0, 16'h0);
    check("rst_regs", regs0[63:0] | regs0[127:64], 64'h0);
    check("rst_cyc", cyc0, 32'h0);
    check("rst_halted", halted0, 1'b0);

    // Zero-wait: LI R1,5; LI R2,7; ADD R3,R1,R2; HALT
    imem[0] = 16'h7205; imem[1] = 16'h7407; imem[2] = 16'h1650; imem[3] = 16'hF000;
    do_reset();
    pulse_start();
    check("start_imem_req", bus0.imem_req, 1'b1);
    wait_idle0(100, "zw_timeout");
    check("zw_r3", regs0[48 +: 16], 16'd12);
    check("zw_halted", halted0, 1'b1);
    check("zw_ret", ret0, 32'd4);
    check("zw_cyc", cyc0, 32'd16);
    check("zw_pc", pc0, 16'd4);

    // Wait states: LI R1,0x10; LI R2,7; ST R2->[R1]; LD R4<-[R1]; HALT
    clear_imem();
    imem[0] = 16'h7210; imem[1] = 16'h7407; imem[2] = 16'h9050; imem[3] = 16'h8840;
    imem[4] = 16'hF000;
    iwait = 2; dwait = 3;
    do_reset();
    u_before = unstable;
    pulse_start();
    wait_idle0(300, "ws_timeout");
    check("ws_r4", regs0[64 +: 16], 16'd7);
    check("ws_dmem", dmem[16], 16'd7);
    check("ws_ret", ret0, 32'd5);
    check("ws_cyc", cyc0, 32'd36);
    check("ws_stable", unstable - u_before, 0);

    // Loop: LI R1,3; LI R2,-1; L: ADD R1,R1,R2; BNZ R1,L; HALT
    clear_imem();
    imem[0] = 16'h7203; imem[1] = 16'h75FF; imem[2] = 16'h1250; imem[3] = 16'hC3FE;
    imem[4] = 16'hF000;
    iwait = 0; dwait = 0;
    do_reset();
    pulse_start();
    wait_idle0(300, "loop_timeout");
    check("loop_r1", regs0[16 +: 16], 16'd0);
    check("loop_r2", regs0[32 +: 16], 16'hFFFF);
    check("loop_pc", pc0, 16'd5);
    check("loop_ret", ret0, 32'd9);
    check("loop_cyc", cyc0, 32'd36);

    // Stop pulsed in D of the first ADD, then resume
    do_reset();
    pulse_start();
    repeat (9) @(negedge clk);
    stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    wait_idle0(50, "stop_timeout");
    check("stop_pc", pc0, 16'd3);
    check("stop_ret", ret0, 32'd3);
    check("stop_r1", regs0[16 +: 16], 16'd2);
    check("stop_halted", halted0, 1'b0);
    @(negedge clk); start = 1'b1; stop = 1'b1;
    @(negedge clk); start = 1'b0; stop = 1'b0;
    check("startstop_idle", state0, 3'd0);
    check("startstop_ireq", bus0.imem_req, 1'b0);
    pulse_start();
    wait_idle0(300, "resume_timeout");
    check("resume_r1", regs0[16 +: 16], 16'd0);
    check("resume_pc", pc0, 16'd5);
    check("resume_ret", ret0, 32'd9);
    check("resume_cyc", cyc0, 32'd36);
    check("resume_halted", halted0, 1'b1);

    // Arithmetic edges on DW=16 and DW=32 side by side
    clear_imem();
    imem[0]  = 16'h7280; imem[1]  = 16'h7402; imem[2]  = 16'h3648; imem[3]  = 16'h36D0;
    imem[4]  = 16'h38D0; imem[5]  = 16'h7BFF; imem[6]  = 16'h7C01; imem[7]  = 16'h4F70;
    imem[8]  = 16'h7000; imem[9]  = 16'h2230; imem[10] = 16'h45A8; imem[11] = 16'h5170;
    imem[12] = 16'hF000;
    do_reset();
    @(negedge clk); start = 1'b1; start32 = 1'b1;
    @(negedge clk); start = 1'b0; start32 = 1'b0;
    n = 0;
    while ((running0 === 1'b1 || running1 === 1'b1) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("arith_timeout", {running0, running1}, 2'b00);
    check("a16_r3_8000", regs0[48 +: 16], 16'h8000);
    check("a16_mlt", regs0[64 +: 16], 16'h0000);
    check("a16_sgt_neg", regs0[112 +: 16], 16'h0000);
    check("a16_sub", regs0[16 +: 16], 16'hFFFF);
    check("a16_sgt_pos", regs0[32 +: 16], 16'h0001);
    check("a16_and", regs0[0 +: 16], 16'h0001);
    check("a32_mlt", regs1[128 +: 32], 32'h0001_0000);
    check("a32_sgt_neg", regs1[224 +: 32], 32'h0);
    check("a32_sub", regs1[32 +: 32], 32'hFFFF_FFFF);
    check("a32_li_neg", regs1[160 +: 32], 32'hFFFF_FFFF);
    check("a32_ret", ret1, 32'd13);

    // Reset while a data request is held pending
    clear_imem();
    imem[0] = 16'h7210; imem[1] = 16'h8840; imem[2] = 16'hF000;
    iwait = 0; dwait = 3;
    do_reset();
    pulse_start();
    n = 0;
    while (state0 !== 3'd4 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("m_reached", state0, 3'd4);
    check("m_dmem_req", bus0.dmem_req, 1'b1);
    check("m_r1", regs0[16 +: 16], 16'h0010);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("mrst_state", state0, 3'd0);
    check("mrst_dreq", bus0.dmem_req, 1'b0);
    check("mrst_ireq", bus0.imem_req, 1'b0);
    check("mrst_pc", pc0, 16'h0);
    check("mrst_regs", regs0[63:0] | regs0[127:64], 64'h0);
    check("mrst_ret", ret0, 32'h0);
    check("mrst_cyc", cyc0, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
